// File: rtl/led_scan_scheduler_if.sv
// Signal bundle between the LED scan scheduler, its row shifter and the panel pins.
// The master side is the scheduler. The slave side is the shifter and panel environment.
`timescale 1ns/1ps
interface led_scan_scheduler_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  enable;
    logic [7:0]            brightness;
    logic                  shift_start;
    logic [ADDR_WIDTH-1:0] shift_row;
    logic [2:0]            shift_plane;
    logic                  shift_done;
    logic                  latch_out;
    logic                  oe_n;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  frame_done;
    logic                  busy;

    modport master (
        input  enable, brightness, shift_done,
        output shift_start, shift_row, shift_plane,
               latch_out, oe_n, addr_out, frame_done, busy
    );

    modport slave (
        output enable, brightness, shift_done,
        input  shift_start, shift_row, shift_plane,
               latch_out, oe_n, addr_out, frame_done, busy
    );
endinterface

// File: rtl/led_scan_scheduler.sv
// LED matrix panel scan scheduler.
// It steps through rows and binary-coded-modulation bit planes and drives the latch
// and output-enable timing. While the current plane is on display, the shifter
// loads the next row/plane pair.
`timescale 1ns/1ps
module led_scan_scheduler #(
    parameter int ADDR_WIDTH  = 3,
    parameter int PLANES      = 8,
    parameter int BASE_TICKS  = 4,
    parameter int LATCH_TICKS = 1,
    parameter int BLANK_TICKS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    led_scan_scheduler_if.master bus
);
    // The timer holds the longest plane period, BASE_TICKS << (PLANES-1), with no overflow.
    localparam int TIMER_WIDTH = $clog2(BASE_TICKS << (PLANES - 1)) + 1;
    localparam int PROD_WIDTH  = TIMER_WIDTH + 8;

    localparam logic [2:0]            LAST_PLANE = 3'(PLANES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ROW_ONE    = ADDR_WIDTH'(1);
    localparam logic [7:0]            LATCH_LAST = 8'(LATCH_TICKS - 1);
    localparam logic [7:0]            BLANK_LAST = 8'(BLANK_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_LATCH,
        ST_BLANK
    } state_t;

    state_t                  state_reg, state_next;
    logic                    shift_start_reg, shift_start_next;
    logic [ADDR_WIDTH-1:0]   row_reg, row_next;
    logic [2:0]              plane_reg, plane_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;
    logic [TIMER_WIDTH-1:0]  on_reg, on_next;
    logic [7:0]              phase_reg, phase_next;

    logic [TIMER_WIDTH-1:0]  period;
    logic [PROD_WIDTH-1:0]   product;
    logic [TIMER_WIDTH-1:0]  on_time;
    logic                    expiring;
    logic                    blank_exit;
    logic                    last_pair;
    logic                    done_seen;

    // In BLANK, row/plane still name the pair that was just latched, so the period comes from them.
    assign period  = TIMER_WIDTH'(BASE_TICKS) << plane_reg;
    assign product = PROD_WIDTH'(period) * PROD_WIDTH'(bus.brightness);
    assign on_time = TIMER_WIDTH'(product >> 8);

    // The display window ends this cycle when the timer is at 1, or it is already idle at 0.
    assign expiring   = (timer_reg <= TIMER_ONE);
    assign blank_exit = (state_reg == ST_BLANK) && (phase_reg == BLANK_LAST);
    assign last_pair  = (row_reg == LAST_ROW) && (plane_reg == LAST_PLANE);
    // A done pulse in the same cycle as shift_start cannot belong to this request.
    assign done_seen  = bus.shift_done && !shift_start_reg;

    // Next-state logic and register updates for the scan sequencer
    always_comb begin
        state_next       = state_reg;
        shift_start_next = 1'b0;
        row_next         = row_reg;
        plane_next       = plane_reg;
        addr_next        = addr_reg;
        timer_next       = (timer_reg != '0) ? timer_reg - TIMER_ONE : '0;
        on_next          = (on_reg != '0) ? on_reg - TIMER_ONE : '0;
        phase_next       = phase_reg;

        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                on_next    = '0;
                if (bus.enable) begin
                    state_next       = ST_SHIFT;
                    shift_start_next = 1'b1;
                    row_next         = '0;
                    plane_next       = '0;
                end
            end
            ST_SHIFT: begin
                if (done_seen) begin
                    if (!bus.enable) begin
                        state_next = ST_IDLE;
                        row_next   = '0;
                        plane_next = '0;
                        timer_next = '0;
                        on_next    = '0;
                    end else if (expiring) begin
                        state_next = ST_LATCH;
                        addr_next  = row_reg;
                        phase_next = '0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.enable) begin
                    state_next = ST_IDLE;
                    row_next   = '0;
                    plane_next = '0;
                    timer_next = '0;
                    on_next    = '0;
                end else if (expiring) begin
                    state_next = ST_LATCH;
                    addr_next  = row_reg;
                    phase_next = '0;
                end
            end
            ST_LATCH: begin
                if (phase_reg == LATCH_LAST) begin
                    state_next = ST_BLANK;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 8'd1;
                end
            end
            ST_BLANK: begin
                if (phase_reg != BLANK_LAST) begin
                    phase_next = phase_reg + 8'd1;
                end else if (!bus.enable) begin
                    state_next = ST_IDLE;
                    row_next   = '0;
                    plane_next = '0;
                    timer_next = '0;
                    on_next    = '0;
                end else begin
                    state_next       = ST_SHIFT;
                    shift_start_next = 1'b1;
                    timer_next       = period;
                    on_next          = on_time;
                    if (plane_reg == LAST_PLANE) begin
                        plane_next = '0;
                        row_next   = row_reg + ROW_ONE;
                    end else begin
                        plane_next = plane_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset acts at once, even in the middle of a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            shift_start_reg <= 1'b0;
            row_reg         <= '0;
            plane_reg       <= '0;
            addr_reg        <= '0;
            timer_reg       <= '0;
            on_reg          <= '0;
            phase_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            shift_start_reg <= shift_start_next;
            row_reg         <= row_next;
            plane_reg       <= plane_next;
            addr_reg        <= addr_next;
            timer_reg       <= timer_next;
            on_reg          <= on_next;
            phase_reg       <= phase_next;
        end
    end

    assign bus.shift_start = shift_start_reg;
    assign bus.shift_row   = row_reg;
    assign bus.shift_plane = plane_reg;
    assign bus.latch_out   = (state_reg == ST_LATCH);
    // LEDs are lit only during the on-time part of a display window, never around a latch.
    assign bus.oe_n        = !((on_reg != '0) &&
                               ((state_reg == ST_SHIFT) || (state_reg == ST_WAIT)));
    assign bus.addr_out    = addr_reg;
    assign bus.frame_done  = blank_exit && last_pair;
    assign bus.busy        = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_led_scan_scheduler.sv
// Self-checking bench for led_scan_scheduler (8 rows, 2 planes, base period 4).
`timescale 1ns/1ps
module tb_led_scan_scheduler;
    localparam int AW   = 3;
    localparam int PL   = 2;
    localparam int BASE = 4;
    localparam int LT   = 1;
    localparam int BT   = 1;
    localparam int ROWS = 1 << AW;
    localparam int NR   = 600;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_scan_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    led_scan_scheduler #(
        .ADDR_WIDTH (AW),
        .PLANES     (PL),
        .BASE_TICKS (BASE),
        .LATCH_TICKS(LT),
        .BLANK_TICKS(BT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int resp_at;
    int frame_at, oe_low, latches, starts, seen_start, found;

    typedef struct {
        int delay;
        int bright;
        int frame_at;
        int oe_low;
        int latches;
    } vec_t;
    vec_t vecs[5];

    logic       done_arr[NR];
    logic [7:0] bright_arr[NR];
    logic       e_start[NR];
    logic       e_latch[NR];
    logic       e_oen[NR];
    logic       e_frame[NR];
    logic [2:0] e_row[NR];
    logic [2:0] e_plane[NR];
    logic [2:0] e_addr[NR];
    logic [13:0] exp_arr[NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] pack_outs();
        return {bus.shift_start, bus.shift_row, bus.shift_plane, bus.latch_out,
                bus.oe_n, bus.addr_out, bus.frame_done, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.enable     = 1'b0;
        bus.shift_done = 1'b0;
        bus.brightness = 8'd0;
        reset          = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        cyc     = -1;
        resp_at = -1;
    endtask

    // Shifter stand-in: it answers every shift_start with a done pulse dly cycles later.
    task automatic step_resp(input int dly);
        tick();
        cyc++;
        bus.shift_done = (cyc == resp_at);
        if (bus.shift_start) resp_at = cyc + dly;
    endtask

    // Timeline model. Pair k starts shifting at s_k and its done arrives at s_k+D_k.
    // The previous pair stays on display for P cycles from s_k. The latch starts at
    // max(s_k+D_k+1, s_k+P_prev). After latch and blank, the next pair starts shifting.
    task automatic build_model();
        int s, l, dly, prev_p, k, p, on, row, plane, s_next;
        for (int t = 0; t < NR; t++) begin
            case (int'($urandom_range(0, 3)))
                0:       bright_arr[t] = 8'd0;
                1:       bright_arr[t] = 8'd255;
                default: bright_arr[t] = 8'($urandom_range(0, 255));
            endcase
            done_arr[t] = 1'b0;
            e_start[t]  = 1'b0;
            e_latch[t]  = 1'b0;
            e_oen[t]    = 1'b1;
            e_frame[t]  = 1'b0;
            e_row[t]    = 3'd0;
            e_plane[t]  = 3'd0;
            e_addr[t]   = 3'd0;
        end
        s = 0;
        prev_p = 0;
        k = 0;
        while (s < NR) begin
            row   = (k / PL) % ROWS;
            plane = k % PL;
            if (int'($urandom_range(0, 3)) == 0) dly = int'($urandom_range(9, 45));
            else dly = int'($urandom_range(1, 8));
            e_start[s] = 1'b1;
            for (int t = s; t < NR; t++) begin
                e_row[t]   = 3'(row);
                e_plane[t] = 3'(plane);
            end
            if (s + dly < NR) done_arr[s + dly] = 1'b1;
            l = (s + dly + 1 > s + prev_p) ? s + dly + 1 : s + prev_p;
            for (int t = l; t < l + LT && t < NR; t++) e_latch[t] = 1'b1;
            for (int t = l; t < NR; t++) e_addr[t] = 3'(row);
            s_next = l + LT + BT;
            p = BASE << plane;
            on = 0;
            if (s_next - 1 < NR) begin
                if (row == ROWS - 1 && plane == PL - 1) e_frame[s_next - 1] = 1'b1;
                on = (p * int'(bright_arr[s_next - 1])) >> 8;
            end
            for (int t = s_next; t < s_next + on && t < NR; t++) e_oen[t] = 1'b0;
            prev_p = p;
            s = s_next;
            k++;
        end
        for (int t = 0; t < NR; t++)
            exp_arr[t] = {e_start[t], e_row[t], e_plane[t], e_latch[t], e_oen[t],
                          e_addr[t], e_frame[t], 1'b1};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: done delay, brightness, frame_done cycle, oe_n-low cycles up to it, latches
        vecs[0] = '{3, 255, 123, 73, 16};
        vecs[1] = '{3, 0, 123, 0, 16};
        vecs[2] = '{40, 255, 687, 73, 16};
        vecs[3] = '{1, 128, 121, 44, 16};
        vecs[4] = '{6, 100, 150, 29, 16};

        bus.enable     = 1'b0;
        bus.shift_done = 1'b0;
        bus.brightness = 8'd0;

        // Reset state, and a shift_done pulse while IDLE must be ignored
        do_reset();
        check("reset_state", 32'(pack_outs()), 32'(14'b0_000_000_0_1_000_0_0));
        bus.shift_done = 1'b1;
        tick();
        bus.shift_done = 1'b0;
        tick();
        check("idle_done_ignored", 32'({bus.busy, bus.shift_start}), 32'(2'b00));
        $display("reset: outputs idle, stray shift_done ignored");

        // Table-driven frame runs with a fixed shifter delay and brightness
        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.brightness = 8'(vecs[v].bright);
            bus.enable     = 1'b1;
            frame_at = -1;
            oe_low   = 0;
            latches  = 0;
            while (frame_at < 0 && cyc < 2000) begin
                step_resp(vecs[v].delay);
                if (!bus.oe_n) oe_low++;
                if (bus.latch_out) latches++;
                if (bus.frame_done) frame_at = cyc;
            end
            check($sformatf("vec%0d_frame_cycle", v), 32'(frame_at), 32'(vecs[v].frame_at));
            check($sformatf("vec%0d_oe_low", v), 32'(oe_low), 32'(vecs[v].oe_low));
            check($sformatf("vec%0d_latches", v), 32'(latches), 32'(vecs[v].latches));
            step_resp(vecs[v].delay);
            check($sformatf("vec%0d_wrap", v),
                  32'({bus.frame_done, bus.shift_start, bus.shift_row, bus.shift_plane}),
                  32'({1'b0, 1'b1, 3'd0, 3'd0}));
            $display("vector %0d: delay=%0d bright=%0d frame_at=%0d oe_low=%0d latches=%0d",
                     v, vecs[v].delay, vecs[v].bright, frame_at, oe_low, latches);
        end

        // Randomized runs compared cycle by cycle against the timeline model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            build_model();
            bus.enable = 1'b1;
            for (int t = 0; t < NR; t++) begin
                tick();
                check($sformatf("run%0d_cycle%0d", r, t), 32'(pack_outs()), 32'(exp_arr[t]));
                bus.shift_done = done_arr[t];
                bus.brightness = bright_arr[t];
            end
            $display("random run %0d: %0d cycles compared", r, NR);
        end

        // Drop enable during SHIFT: the handshake completes, then the scheduler goes IDLE and restarts at row 0 plane 0
        do_reset();
        bus.brightness = 8'd255;
        bus.enable     = 1'b1;
        starts = 0;
        while (starts < 2 && cyc < 200) begin
            step_resp(3);
            if (bus.shift_start) starts++;
        end
        check("drop_second_start", 32'(starts), 32'd2);
        bus.enable = 1'b0;
        seen_start = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.shift_done = 1'b0;
            if (bus.shift_start) seen_start++;
        end
        check("drop_still_busy", 32'(bus.busy), 32'd1);
        bus.shift_done = 1'b1;
        tick();
        bus.shift_done = 1'b0;
        check("drop_idle", 32'({bus.busy, bus.oe_n, bus.shift_start, bus.shift_row, bus.shift_plane}),
              32'({1'b0, 1'b1, 1'b0, 3'd0, 3'd0}));
        for (int i = 0; i < 10; i++) begin
            bus.shift_done = (i == 0);
            tick();
            if (bus.shift_start) seen_start++;
        end
        bus.shift_done = 1'b0;
        check("drop_no_restart", 32'(seen_start), 32'd0);
        check("drop_idle_done_ignored", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;
        tick();
        check("reenable_start", 32'({bus.shift_start, bus.shift_row, bus.shift_plane}),
              32'({1'b1, 3'd0, 3'd0}));
        $display("enable drop in SHIFT: idle after done, restart at row 0 plane 0");

        // Drop enable during LATCH: BLANK finishes, then IDLE with no new shift
        do_reset();
        bus.brightness = 8'd255;
        bus.enable     = 1'b1;
        found = 0;
        while (found == 0 && cyc < 200) begin
            step_resp(3);
            if (bus.latch_out) found = 1;
        end
        check("blank_found_latch", 32'(found), 32'd1);
        bus.enable = 1'b0;
        tick();
        check("blank_phase", 32'({bus.busy, bus.latch_out, bus.oe_n}), 32'(3'b101));
        tick();
        check("blank_exit_idle", 32'({bus.busy, bus.shift_start, bus.oe_n}), 32'(3'b001));
        $display("enable drop in LATCH: idle at blank exit");

        // Assert reset between clock edges while LEDs are lit
        do_reset();
        bus.brightness = 8'd255;
        bus.enable     = 1'b1;
        found = 0;
        while (found == 0 && cyc < 200) begin
            step_resp(3);
            if (!bus.oe_n) found = 1;
        end
        check("areset_found_display", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_display", 32'({bus.oe_n, bus.latch_out, bus.busy, bus.shift_start}),
              32'(4'b1000));
        $display("async reset during display: outputs dark at once");

        // Assert reset between clock edges while latching a nonzero row
        do_reset();
        bus.brightness = 8'd255;
        bus.enable     = 1'b1;
        found = 0;
        while (found == 0 && cyc < 200) begin
            step_resp(3);
            if (bus.latch_out && bus.addr_out != 3'd0) found = 1;
        end
        check("areset_found_latch", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_latch", 32'({bus.latch_out, bus.oe_n, bus.busy, bus.addr_out}),
              32'({1'b0, 1'b1, 1'b0, 3'd0}));
        $display("async reset during latch: latch dropped at once");
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
